prewish_pattern_sequencer: RTL and testbench

Parametrised successor to the board-level mask generator. Produces new blink masks for the prewish mentor/blinky chain from a writable pattern table on a periodic tick (auto mode), or from a DIP-switch value captured on a debounced load button (manual mode). Each new mask is delivered as DAT_O plus a STB_O pulse of configurable length. Sits between the syscon signals and prewish_mentor.

---
 rtl/prewish_pattern_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_prewish_pattern_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prewish_pattern_sequencer.sv
// prewish_pattern_sequencer
// Produces blink masks for the prewish mentor/blinky chain. In auto mode the
// next entry of a writable pattern table is issued on every period tick; in
// manual mode the DIP-switch value is issued on a debounced load-button press.
// Every issued mask appears on DAT_O with an STB_O pulse STB_CYCLES long,
// followed by at least one idle cycle before the next strobe.
//
// Ports:
//   CLK_I       system clock (only clock)
//   RST_I       synchronous active-high reset
//   i_mode      00 hold, 01 auto, 10 manual, 11 auto+manual
//   i_tbl_we    pattern table write enable
//   i_tbl_addr  pattern table write address
//   i_tbl_data  pattern table write data
//   i_dip       DIP switch value, captured when a manual mask is issued
//   i_load_btn  raw asynchronous load button, active high
//   STB_O       strobe to mentor
//   DAT_O       mask to mentor, changes only when a new mask is issued
//   o_index     next table index to be issued
//   o_alive     period counter MSB (heartbeat)
module prewish_pattern_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int IDX_BITS      = 3,
    parameter int PERIOD_BITS   = 28,
    parameter int STB_CYCLES    = 2,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic [1:0]            i_mode,
    input  logic                  i_tbl_we,
    input  logic [IDX_BITS-1:0]   i_tbl_addr,
    input  logic [DATA_WIDTH-1:0] i_tbl_data,
    input  logic [DATA_WIDTH-1:0] i_dip,
    input  logic                  i_load_btn,
    output logic                  STB_O,
    output logic [DATA_WIDTH-1:0] DAT_O,
    output logic [IDX_BITS-1:0]   o_index,
    output logic                  o_alive
);

    localparam int NUM_PATTERNS = 2 ** IDX_BITS;
    localparam int STB_CNT_BITS = (STB_CYCLES > 1) ? $clog2(STB_CYCLES) : 1;
    localparam logic [STB_CNT_BITS-1:0] STB_LAST = STB_CNT_BITS'(STB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PERIOD_BITS-1:0]   period_q, period_d;
    logic [1:0]               sync_q, sync_d;
    logic                     deb_q, deb_d;
    logic [DEBOUNCE_BITS-1:0] deb_cnt_q, deb_cnt_d;
    logic [STB_CNT_BITS-1:0]  stb_cnt_q, stb_cnt_d;
    logic                     stb_q, stb_d;
    logic [DATA_WIDTH-1:0]    dat_q, dat_d;
    logic [IDX_BITS-1:0]      idx_q, idx_d;
    logic                     pend_auto_q, pend_auto_d;
    logic                     pend_man_q, pend_man_d;
    logic [DATA_WIDTH-1:0]    table_q [NUM_PATTERNS];
    logic [DATA_WIDTH-1:0]    table_d [NUM_PATTERNS];

    logic tick_s;
    logic press_s;
    logic auto_ev_s;
    logic man_ev_s;

    // The debounced value flips in the cycle the counter is saturated while the
    // synchronised input still disagrees; a press is that flip towards 1.
    assign tick_s    = &period_q;
    assign press_s   = (&deb_cnt_q) & (sync_q[1] != deb_q) & sync_q[1];
    assign auto_ev_s = tick_s & i_mode[0];
    assign man_ev_s  = press_s & i_mode[1];

    assign STB_O   = stb_q;
    assign DAT_O   = dat_q;
    assign o_index = idx_q;
    assign o_alive = period_q[PERIOD_BITS-1];

    // Free-running period counter, button synchroniser/debouncer and table writes.
    always_comb begin
        period_d = period_q + PERIOD_BITS'(1);
        sync_d   = {sync_q[0], i_load_btn};
        deb_d    = deb_q;
        if (sync_q[1] == deb_q) begin
            deb_cnt_d = '0;
        end else if (&deb_cnt_q) begin
            deb_d     = sync_q[1];
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEBOUNCE_BITS'(1);
        end
        table_d = table_q;
        if (i_tbl_we) begin
            table_d[i_tbl_addr] = i_tbl_data;
        end else begin
            table_d = table_q;
        end
    end

    // Issue FSM: picks the source, drives the strobe and tracks pending events.
    always_comb begin
        state_d     = state_q;
        stb_d       = stb_q;
        stb_cnt_d   = stb_cnt_q;
        dat_d       = dat_q;
        idx_d       = idx_q;
        // A cleared mode bit drops that source's waiting event at once.
        pend_auto_d = pend_auto_q & i_mode[0];
        pend_man_d  = pend_man_q & i_mode[1];
        case (state_q)
            IDLE: begin
                if (man_ev_s || pend_man_d) begin
                    dat_d       = i_dip;
                    stb_d       = 1'b1;
                    stb_cnt_d   = '0;
                    state_d     = STROBE;
                    pend_man_d  = 1'b0;
                    // A simultaneous tick loses to manual and waits its turn.
                    pend_auto_d = pend_auto_d | auto_ev_s;
                end else if (auto_ev_s || pend_auto_d) begin
                    // Reads the pre-write table, so a same-cycle write is not seen.
                    dat_d       = table_q[idx_q];
                    idx_d       = idx_q + IDX_BITS'(1);
                    stb_d       = 1'b1;
                    stb_cnt_d   = '0;
                    state_d     = STROBE;
                    pend_auto_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            STROBE: begin
                pend_auto_d = pend_auto_d | auto_ev_s;
                pend_man_d  = pend_man_d | man_ev_s;
                if (stb_cnt_q == STB_LAST) begin
                    stb_d   = 1'b0;
                    state_d = GAP;
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_CNT_BITS'(1);
                end
            end
            GAP: begin
                pend_auto_d = pend_auto_d | auto_ev_s;
                pend_man_d  = pend_man_d | man_ev_s;
                stb_d       = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; table entries reset to MSB | index.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= IDLE;
            period_q    <= '0;
            sync_q      <= 2'b00;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            stb_q       <= 1'b0;
            dat_q       <= '0;
            idx_q       <= '0;
            pend_auto_q <= 1'b0;
            pend_man_q  <= 1'b0;
            for (int k = 0; k < NUM_PATTERNS; k++) begin
                table_q[k] <= {1'b1, (DATA_WIDTH-1)'(k)};
            end
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            sync_q      <= sync_d;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            stb_q       <= stb_d;
            dat_q       <= dat_d;
            idx_q       <= idx_d;
            pend_auto_q <= pend_auto_d;
            pend_man_q  <= pend_man_d;
            table_q     <= table_d;
        end
    end

endmodule

// File: tb/tb_prewish_pattern_sequencer.sv
// Self-checking bench for prewish_pattern_sequencer with a cycle-level
// behavioural model plus directed scenarios with literal expectations.
module tb_prewish_pattern_sequencer;

    localparam int DW     = 8;
    localparam int IB     = 3;
    localparam int PB     = 4;
    localparam int SC     = 2;
    localparam int DB     = 2;
    localparam int NP     = 1 << IB;
    localparam int PERIOD = 1 << PB;
    localparam int DB_N   = 1 << DB;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          we;
    logic [IB-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] dip;
    logic          btn;
    logic          stb;
    logic [DW-1:0] dat;
    logic [IB-1:0] idx;
    logic          alive;

    prewish_pattern_sequencer #(
        .DATA_WIDTH(DW), .IDX_BITS(IB), .PERIOD_BITS(PB),
        .STB_CYCLES(SC), .DEBOUNCE_BITS(DB)
    ) dut (
        .CLK_I(clk), .RST_I(rst), .i_mode(mode), .i_tbl_we(we),
        .i_tbl_addr(addr), .i_tbl_data(wdata), .i_dip(dip),
        .i_load_btn(btn), .STB_O(stb), .DAT_O(dat), .o_index(idx),
        .o_alive(alive)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int            m_period;
    bit            m_sync1, m_sync2, m_deb;
    int            m_run;      // consecutive cycles the synced button disagreed with m_deb
    int            m_busy;     // edges left until the issuer is free again
    bit            m_stb;
    logic [DW-1:0] m_dat;
    int            m_idx;
    bit            m_pa, m_pm;
    logic [DW-1:0] m_table [NP];
    bit            model_valid = 1'b0;

    task model_step();
        bit tick, press, a_ev, m_ev, pa, pm;
        if (rst) begin
            m_period = 0; m_sync1 = 0; m_sync2 = 0; m_deb = 0; m_run = 0;
            m_busy = 0; m_stb = 0; m_dat = '0; m_idx = 0; m_pa = 0; m_pm = 0;
            for (int k = 0; k < NP; k++) m_table[k] = 8'h80 | 8'(k);
            model_valid = 1'b1;
        end else begin
            tick  = (m_period == PERIOD - 1);
            press = 1'b0;
            if (m_sync2 != m_deb) begin
                if (m_run == DB_N - 1) begin
                    press = m_sync2;
                    m_deb = m_sync2;
                    m_run = 0;
                end else m_run++;
            end else m_run = 0;
            m_sync2  = m_sync1;
            m_sync1  = btn;
            m_period = (m_period + 1) % PERIOD;
            a_ev = tick & mode[0];
            m_ev = press & mode[1];
            pa   = m_pa & mode[0];
            pm   = m_pm & mode[1];
            if (m_busy == 0) begin
                if (m_ev || pm) begin
                    m_dat = dip; m_stb = 1; m_busy = SC + 1; pm = 0;
                    if (a_ev) pa = 1;
                end else if (a_ev || pa) begin
                    m_dat = m_table[m_idx]; m_idx = (m_idx + 1) % NP;
                    m_stb = 1; m_busy = SC + 1; pa = 0;
                end
            end else begin
                m_busy--;
                m_stb = (m_busy > 1);
                if (a_ev) pa = 1;
                if (m_ev) pm = 1;
            end
            m_pa = pa;
            m_pm = pm;
            if (we) m_table[addr] = wdata;
        end
    endtask

    // ---------------- compare process ----------------
    int            cyc = 0;
    int            rel_cyc = 0;
    int            toggles = 0;
    logic          prev_stb = 1'b0;
    logic          prev_alive = 1'b0;
    logic [DW-1:0] obs_dat [$];
    int            obs_t [$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            @(negedge clk);
            if (model_valid) begin
                check("stb", 32'(stb), 32'(m_stb));
                check("dat", 32'(dat), 32'(m_dat));
                check("index", 32'(idx), 32'(m_idx));
                check("alive", 32'(alive), 32'(m_period >= PERIOD / 2));
                if (stb && !prev_stb) begin
                    obs_dat.push_back(dat);
                    obs_t.push_back(cyc);
                end
                if (alive != prev_alive) toggles++;
            end
            prev_stb   = stb;
            prev_alive = alive;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        mode = m;
        rst  = 1'b1;
        step(2);
        rst  = 1'b0;
        obs_dat.delete();
        obs_t.delete();
        rel_cyc = cyc;
        toggles = 0;
    endtask

    logic [DW-1:0] exp1 [9] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h80};

    initial begin
        rst = 1'b1; mode = 2'b00; we = 1'b0; addr = '0; wdata = '0; dip = '0; btn = 1'b0;

        // Auto mode: table sequence, 16-cycle spacing, index wrap.
        do_reset(2'b01);
        step(150);
        check("t1_count", 32'(obs_dat.size()), 32'd9);
        for (int i = 0; i < obs_dat.size() && i < 9; i++) check("t1_dat", 32'(obs_dat[i]), 32'(exp1[i]));
        if (obs_t.size() >= 2) begin
            check("t1_first_latency", 32'(obs_t[0] - rel_cyc), 32'd16);
            check("t1_spacing", 32'(obs_t[1] - obs_t[0]), 32'd16);
        end
        check("t1_index_wrapped", 32'(idx), 32'd1);

        // Table writes: early write visible, same-cycle write not.
        do_reset(2'b01);
        we = 1'b1; addr = 3'd0; wdata = 8'hA5;
        step(1);
        we = 1'b0;
        step(30);
        we = 1'b1; addr = 3'd1; wdata = 8'h3C;
        step(1);
        we = 1'b0;
        step(10);
        check("t2_count", 32'(obs_dat.size()), 32'd2);
        if (obs_dat.size() >= 2) begin
            check("t2_written_entry", 32'(obs_dat[0]), 32'hA5);
            check("t2_same_cycle_old", 32'(obs_dat[1]), 32'h81);
        end

        // Manual mode: short press, real press, bounce.
        do_reset(2'b10);
        dip = 8'h5A;
        btn = 1'b1; step(3); btn = 1'b0; step(10);
        check("t3_short_press", 32'(obs_dat.size()), 32'd0);
        btn = 1'b1; step(10); btn = 1'b0; step(12);
        check("t3_press_count", 32'(obs_dat.size()), 32'd1);
        if (obs_dat.size() >= 1) check("t3_press_dat", 32'(obs_dat[0]), 32'h5A);
        check("t3_index_kept", 32'(idx), 32'd0);
        for (int i = 0; i < 20; i++) begin
            btn = ~btn;
            step(1);
        end
        btn = 1'b0;
        step(10);
        check("t3_bounce", 32'(obs_dat.size()), 32'd1);

        // Auto+manual: press qualifies in the tick cycle, manual first.
        do_reset(2'b11);
        dip = 8'hC3;
        step(10);
        btn = 1'b1; step(10); btn = 1'b0;
        step(9);
        check("t4_count", 32'(obs_dat.size()), 32'd2);
        if (obs_dat.size() >= 2) begin
            check("t4_manual_first", 32'(obs_dat[0]), 32'hC3);
            check("t4_auto_second", 32'(obs_dat[1]), 32'h80);
            check("t4_latency", 32'(obs_t[0] - rel_cyc), 32'd16);
            check("t4_gap", 32'(obs_t[1] - obs_t[0]), 32'd4);
        end
        check("t4_index", 32'(idx), 32'd1);

        // Reset while the strobe is high.
        do_reset(2'b01);
        step(17);
        check("t5_stb_before", 32'(stb), 32'd1);
        check("t5_dat_before", 32'(dat), 32'h80);
        rst = 1'b1;
        step(1);
        check("t5_stb_reset", 32'(stb), 32'd0);
        check("t5_dat_reset", 32'(dat), 32'd0);
        check("t5_idx_reset", 32'(idx), 32'd0);
        rst = 1'b0;
        obs_dat.delete();
        obs_t.delete();
        rel_cyc = cyc;
        step(20);
        check("t5_count_after", 32'(obs_dat.size()), 32'd1);
        if (obs_dat.size() >= 1) begin
            check("t5_dat_after", 32'(obs_dat[0]), 32'h80);
            check("t5_latency_after", 32'(obs_t[0] - rel_cyc), 32'd16);
        end

        // Hold mode: no strobes even with a press, heartbeat keeps running.
        do_reset(2'b00);
        step(5);
        btn = 1'b1; step(10); btn = 1'b0;
        step(50);
        check("t6_no_strobe", 32'(obs_dat.size()), 32'd0);
        check("t6_alive_toggles", 32'(toggles), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
